// File: rtl/lsu_stage.sv
// Load/store stage for the rv32i core: formats one memory access, runs a single
// outstanding req/ack transaction and returns the extended load result or a fault.
module lsu_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic [1:0]  fault_code,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    // Handshake: mem_req and its payload hold steady until the edge that sees
    // mem_ack=1; that edge completes the transfer and mem_rdata is taken then.
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic [1:0]  lane, lane_nx;
    logic [2:0]  f3_q, f3_nx;
    logic        store_q, store_nx;
    logic        busy_nx, done_nx, req_nx, we_nx;
    logic [31:0] load_nx, maddr_nx, wdata_nx;
    logic [1:0]  fault_nx;
    logic [3:0]  wstrb_nx;

    logic        accept, legal, misaligned;
    logic [3:0]  strb_fmt;
    logic [31:0] wdata_fmt, load_fmt;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Request-side decode and formatting from the live inputs, response-side
    // formatting from the lane/funct3 captured at accept.
    always_comb begin
        accept = (state == IDLE) && start && (is_load ^ is_store);

        case (funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = is_load;
            default:                legal = 1'b0;
        endcase

        case (funct3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = |addr[1:0];
            default: misaligned = 1'b0;
        endcase

        case (funct3[1:0])
            2'b00: begin
                strb_fmt  = 4'b0001 << addr[1:0];
                wdata_fmt = {4{store_data[7:0]}};
            end
            2'b01: begin
                strb_fmt  = 4'b0011 << addr[1:0];
                wdata_fmt = {2{store_data[15:0]}};
            end
            default: begin
                strb_fmt  = 4'b1111;
                wdata_fmt = store_data;
            end
        endcase

        case (lane)
            2'd0:    rbyte = mem_rdata[7:0];
            2'd1:    rbyte = mem_rdata[15:8];
            2'd2:    rbyte = mem_rdata[23:16];
            default: rbyte = mem_rdata[31:24];
        endcase
        rhalf = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (f3_q)
            3'b000:  load_fmt = {{24{rbyte[7]}}, rbyte};
            3'b001:  load_fmt = {{16{rhalf[15]}}, rhalf};
            3'b010:  load_fmt = mem_rdata;
            3'b100:  load_fmt = {24'd0, rbyte};
            3'b101:  load_fmt = {16'd0, rhalf};
            default: load_fmt = 32'd0;
        endcase
        if (store_q) load_fmt = 32'd0;
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        lane_nx  = lane;
        f3_nx    = f3_q;
        store_nx = store_q;
        done_nx  = 1'b0;
        load_nx  = load_data;
        fault_nx = fault_code;
        req_nx   = mem_req;
        we_nx    = mem_we;
        maddr_nx = mem_addr;
        wdata_nx = mem_wdata;
        wstrb_nx = mem_wstrb;

        case (state)
            IDLE: begin
                if (accept) begin
                    lane_nx  = addr[1:0];
                    f3_nx    = funct3;
                    store_nx = is_store;
                    cnt_nx   = 16'd0;
                    load_nx  = 32'd0;
                    if (!legal) begin
                        state_nx = DONE;
                        fault_nx = 2'b10;
                    end else if (misaligned) begin
                        state_nx = DONE;
                        fault_nx = 2'b01;
                    end else begin
                        state_nx = REQ;
                        fault_nx = 2'b00;
                        req_nx   = 1'b1;
                        we_nx    = is_store;
                        maddr_nx = {addr[31:2], 2'b00};
                        wdata_nx = is_store ? wdata_fmt : 32'd0;
                        wstrb_nx = is_store ? strb_fmt : 4'b0000;
                    end
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_nx = DONE;
                    done_nx  = 1'b1;
                    load_nx  = load_fmt;
                    fault_nx = 2'b00;
                    req_nx   = 1'b0;
                    we_nx    = 1'b0;
                    wstrb_nx = 4'b0000;
                end else if (cnt == TO_LAST) begin
                    state_nx = DONE;
                    done_nx  = 1'b1;
                    load_nx  = 32'd0;
                    fault_nx = 2'b11;
                    req_nx   = 1'b0;
                    we_nx    = 1'b0;
                    wstrb_nx = 4'b0000;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            default: begin
                // Fault paths arrive here with done low and pulse it one edge later.
                if (done) state_nx = IDLE;
                else      done_nx  = 1'b1;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 16'd0;
            lane       <= 2'd0;
            f3_q       <= 3'd0;
            store_q    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_data  <= 32'd0;
            fault_code <= 2'b00;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            mem_wstrb  <= 4'b0000;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            lane       <= lane_nx;
            f3_q       <= f3_nx;
            store_q    <= store_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            load_data  <= load_nx;
            fault_code <= fault_nx;
            mem_req    <= req_nx;
            mem_we     <= we_nx;
            mem_addr   <= maddr_nx;
            mem_wdata  <= wdata_nx;
            mem_wstrb  <= wstrb_nx;
        end
    end
endmodule

// File: tb/tb_lsu_stage.sv
// Bench for lsu_stage: directed scenarios plus randomized accesses checked
// against an arithmetic model of load/store formatting, faults and latency.
module tb_lsu_stage;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, is_load = 1'b0, is_store = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0, store_data = 32'd0;
    logic        busy, done, mem_req, mem_we;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [1:0]  fault_code;
    logic [3:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    // Observations from the most recent transaction
    int          r_req, r_done, r_width;
    logic [31:0] r_addr, r_wdata, r_ld;
    logic [3:0]  r_wstrb;
    logic        r_we;
    logic [1:0]  r_fc;

    lsu_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .addr(addr), .store_data(store_data), .busy(busy), .done(done),
        .load_data(load_data), .fault_code(fault_code), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [1:0] m_fault(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int  size;
        bit  ok;
        if (st) ok = (f3 <= 3'd2);
        else    ok = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        if (!ok) return 2'b10;
        size = 1 << (f3 % 4);
        if ((a % size) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [7:0]         b;
        logic [15:0]        h;
        logic signed [31:0] s;
        b = 8'(rd >> (8 * (a % 4)));
        h = 16'(rd >> (16 * ((a % 4) / 2)));
        case (f3)
            3'd0: begin s = $signed(b); return s; end
            3'd1: begin s = $signed(h); return s; end
            3'd2: return rd;
            3'd4: return 32'(b);
            3'd5: return 32'(h);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [31:0] a);
        int size;
        size = 1 << (f3 % 4);
        if (size == 4) return 4'hF;
        return 4'(((1 << size) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        case (f3 % 4)
            0: return 32'(sd[7:0]) * 32'h0101_0101;
            1: return 32'(sd[15:0]) * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    // ---------------- driver ----------------
    // Issues one start, acks at edge N+ack_after (0 = never), and records what
    // the DUT shows until it is back in IDLE after done, bounded to 40 cycles.
    task automatic do_txn(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input int ack_after, input logic [31:0] rd);
        is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd; start = 1'b1;
        r_req = 0; r_done = -1; r_width = 0;
        r_addr = '0; r_wdata = '0; r_wstrb = '0; r_we = 1'b0; r_ld = '0; r_fc = '0;
        @(posedge clk); #1;
        start = 1'b0; is_load = 1'b0; is_store = 1'b0;
        for (int e = 0; e < 40; e++) begin
            if (mem_req) begin
                if (r_req == 0) begin
                    r_addr = mem_addr; r_wdata = mem_wdata; r_wstrb = mem_wstrb; r_we = mem_we;
                end
                r_req++;
            end
            if (done) begin
                if (r_done < 0) r_done = e;
                r_width++;
                r_ld = load_data;
                r_fc = fault_code;
            end
            mem_ack   = (ack_after > 0) && (e + 1 == ack_after);
            mem_rdata = mem_ack ? rd : $urandom;
            @(posedge clk); #1;
            if (r_done >= 0 && !done && !busy) break;
        end
        mem_ack = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({busy, done, mem_req, mem_we} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctrl got busy/done/req/we=%b want 0000", {busy, done, mem_req, mem_we});
        end
        n_vec++;
        if ({load_data, fault_code} !== 34'd0) begin
            n_err++;
            $display("FAIL reset_result got ld=%h fc=%b want 0", load_data, fault_code);
        end
        n_vec++;
        if ({mem_addr, mem_wdata, mem_wstrb} !== 68'd0) begin
            n_err++;
            $display("FAIL reset_mem got addr=%h wdata=%h wstrb=%b want 0", mem_addr, mem_wdata, mem_wstrb);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_loads();
        do_txn(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'd0, 2, 32'h80FF_1234);
        n_vec++;
        if ({r_addr, r_wstrb, r_we} !== {32'h0000_1000, 4'b0000, 1'b0}) begin
            n_err++;
            $display("FAIL lb_req got addr=%h wstrb=%b we=%b want 00001000 0000 0", r_addr, r_wstrb, r_we);
        end
        n_vec++;
        if ({r_ld, r_fc} !== {32'hFFFF_FF80, 2'b00}) begin
            n_err++;
            $display("FAIL lb_data got ld=%h fc=%b want ffffff80 00", r_ld, r_fc);
        end
        n_vec++;
        if (r_done != 2 || r_width != 1 || r_req != 2) begin
            n_err++;
            $display("FAIL lb_timing got done@%0d width=%0d req=%0d want 2 1 2", r_done, r_width, r_req);
        end
        do_txn(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'd0, 1, 32'hBEEF_0001);
        n_vec++;
        if (r_ld !== 32'h0000_BEEF || r_done != 1) begin
            n_err++;
            $display("FAIL lhu got ld=%h done@%0d want 0000beef 1", r_ld, r_done);
        end
        do_txn(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'd0, 1, 32'hBEEF_0001);
        n_vec++;
        if (r_ld !== 32'hFFFF_BEEF) begin
            n_err++;
            $display("FAIL lh got ld=%h want ffffbeef", r_ld);
        end
    endtask

    task automatic test_stores();
        do_txn(1'b0, 1'b1, 3'b001, 32'h0000_0010, 32'h1234_ABCD, 1, 32'hDEAD_BEEF);
        n_vec++;
        if ({r_we, r_wdata, r_wstrb, r_addr} !== {1'b1, 32'hABCD_ABCD, 4'b0011, 32'h10}) begin
            n_err++;
            $display("FAIL sh got we=%b wdata=%h wstrb=%b addr=%h want 1 abcdabcd 0011 00000010",
                     r_we, r_wdata, r_wstrb, r_addr);
        end
        n_vec++;
        if ({r_ld, r_fc} !== 34'd0) begin
            n_err++;
            $display("FAIL sh_result got ld=%h fc=%b want 0 00", r_ld, r_fc);
        end
        do_txn(1'b0, 1'b1, 3'b000, 32'h0000_0013, 32'h1234_ABCD, 2, 32'd0);
        n_vec++;
        if ({r_wdata, r_wstrb, r_addr} !== {32'hCDCD_CDCD, 4'b1000, 32'h10}) begin
            n_err++;
            $display("FAIL sb got wdata=%h wstrb=%b addr=%h want cdcdcdcd 1000 00000010", r_wdata, r_wstrb, r_addr);
        end
    endtask

    task automatic test_faults();
        do_txn(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'd0, 0, 32'd0);
        n_vec++;
        if (r_req != 0 || r_done != 1 || r_width != 1 || r_fc !== 2'b01 || r_ld !== 32'd0) begin
            n_err++;
            $display("FAIL lw_misaligned got req=%0d done@%0d width=%0d fc=%b ld=%h want 0 1 1 01 0",
                     r_req, r_done, r_width, r_fc, r_ld);
        end
        do_txn(1'b1, 1'b0, 3'b011, 32'h0000_0005, 32'd0, 0, 32'd0);
        n_vec++;
        if (r_req != 0 || r_done != 1 || r_fc !== 2'b10) begin
            n_err++;
            $display("FAIL illegal_priority got req=%0d done@%0d fc=%b want 0 1 10", r_req, r_done, r_fc);
        end
    endtask

    task automatic test_timeout();
        int hits;
        do_txn(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0, 0, 32'd0);
        n_vec++;
        if (r_req != TO || r_done != TO || r_fc !== 2'b11 || r_ld !== 32'd0) begin
            n_err++;
            $display("FAIL timeout got req=%0d done@%0d fc=%b ld=%h want %0d %0d 11 0",
                     r_req, r_done, r_fc, r_ld, TO, TO);
        end
        hits = 0;
        mem_ack = 1'b1;
        mem_rdata = 32'h1111_2222;
        repeat (3) begin
            @(posedge clk); #1;
            if (busy || done || mem_req) hits++;
        end
        mem_ack = 1'b0;
        n_vec++;
        if (hits != 0 || fault_code !== 2'b11 || load_data !== 32'd0) begin
            n_err++;
            $display("FAIL late_ack got activity=%0d fc=%b ld=%h want 0 11 0", hits, fault_code, load_data);
        end
    endtask

    task automatic test_ignored_starts();
        is_load = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h40; start = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL both_flags got busy=%b req=%b want 0 0", busy, mem_req);
        end
        is_load = 1'b0; is_store = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL no_flags got busy=%b req=%b want 0 0", busy, mem_req);
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid();
        int dones;
        is_load = 1'b1; funct3 = 3'b010; addr = 32'h0000_0040; start = 1'b1;
        @(posedge clk); #1;
        addr = 32'h0000_0080;
        @(posedge clk); #1;
        start = 1'b0; is_load = 1'b0;
        n_vec++;
        if (mem_req !== 1'b1 || busy !== 1'b1 || mem_addr !== 32'h0000_0040) begin
            n_err++;
            $display("FAIL start_while_busy got req=%b busy=%b addr=%h want 1 1 00000040", mem_req, busy, mem_addr);
        end
        #3 rst = 1'b1;
        #1;
        n_vec++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset got req=%b busy=%b want 0 0", mem_req, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        dones = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        n_vec++;
        if (dones != 0 || {load_data, fault_code} !== 34'd0) begin
            n_err++;
            $display("FAIL reset_no_done got activity=%0d ld=%h fc=%b want 0 0 00", dones, load_data, fault_code);
        end
    endtask

    task automatic test_random();
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a, sd, rd, exp_ld;
        logic [1:0]  exp_fc;
        int          ack, exp_lat, exp_req;
        for (int i = 0; i < 60; i++) begin
            st  = 1'($urandom_range(0, 1));
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            sd  = $urandom;
            rd  = $urandom;
            ack = $urandom_range(1, TO + 1);
            exp_fc = m_fault(st, f3, a);
            if (exp_fc != 2'b00) begin
                exp_lat = 1; exp_req = 0; exp_ld = 32'd0;
            end else if (ack > TO) begin
                exp_lat = TO; exp_req = TO; exp_ld = 32'd0; exp_fc = 2'b11;
            end else begin
                exp_lat = ack; exp_req = ack; exp_ld = st ? 32'd0 : m_load(f3, a, rd);
            end
            exp_q.push_back(exp_ld);
            do_txn(!st, st, f3, a, sd, ack, rd);
            n_vec++;
            if (r_fc !== exp_fc) begin
                n_err++;
                $display("FAIL rnd_fault[%0d] got %b want %b (st=%b f3=%0d a=%h)", i, r_fc, exp_fc, st, f3, a);
            end
            n_vec++;
            if (r_done != exp_lat || r_req != exp_req || r_width != 1) begin
                n_err++;
                $display("FAIL rnd_timing[%0d] got done@%0d req=%0d width=%0d want %0d %0d 1",
                         i, r_done, r_req, r_width, exp_lat, exp_req);
            end
            n_vec++;
            if (r_ld !== exp_q[0]) begin
                n_err++;
                $display("FAIL rnd_load[%0d] got %h want %h (f3=%0d a=%h rd=%h)", i, r_ld, exp_q[0], f3, a, rd);
            end
            void'(exp_q.pop_front());
            if (exp_req > 0) begin
                n_vec++;
                if (r_addr !== {a[31:2], 2'b00} || r_we !== st ||
                    (st && (r_wstrb !== m_wstrb(f3, a) || r_wdata !== m_wdata(f3, sd))) ||
                    (!st && r_wstrb !== 4'b0000)) begin
                    n_err++;
                    $display("FAIL rnd_mem[%0d] got addr=%h we=%b wstrb=%b wdata=%h (f3=%0d a=%h sd=%h)",
                             i, r_addr, r_we, r_wstrb, r_wdata, f3, a, sd);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_faults();
        test_timeout();
        test_ignored_starts();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
